// File: rtl/ksa_pkg.sv
// Shared definitions for the pipelined Kogge-Stone adder: mode encoding,
// prefix-depth helper and parameter legality check.
package ksa_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    // Number of prefix levels for a given operand width (ceil log2).
    function automatic int ksa_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic bit ksa_params_ok(input int width, input int approx_k);
        return (width >= 4) && (width <= 64) && ((width & (width - 1)) == 0) &&
               (approx_k >= 1) && (approx_k <= width - 1);
    endfunction

endpackage

// File: rtl/ksa_prefix_level.sv
// One combinational Kogge-Stone prefix level combining each bit with the bit SPAN below.
// Latency 0 (pure logic); no flow control, the enclosing pipeline owns backpressure.
module ksa_prefix_level #(
    parameter int WIDTH = 16,
    parameter int SPAN  = 1
) (
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] p_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= SPAN) begin : g_combine
            assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-SPAN]);
            assign p_out[i] = p_in[i] & p_in[i-SPAN];
        end else begin : g_pass
            assign g_out[i] = g_in[i];
            assign p_out[i] = p_in[i];
        end
    end

endmodule

// File: rtl/ksa_pipe_adder.sv
// Pipelined WIDTH-bit Kogge-Stone adder with per-beat exact / lower-part-OR approximate mode.
// Latency log2(WIDTH)+2 cycles; a single global stall (out_valid & ~out_ready) freezes every stage.
module ksa_pipe_adder
    import ksa_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int APPROX_K = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int L = ksa_clog2(WIDTH);

    if (!ksa_params_ok(WIDTH, APPROX_K)) begin : g_param_check
        $error("ksa_pipe_adder: WIDTH must be a power of two in 4..64 and APPROX_K in 1..WIDTH-1");
    end

    // Everything one beat needs on its way to the output stage.
    typedef struct packed {
        logic [WIDTH-1:0]    g;
        logic [WIDTH-1:0]    p;
        logic [WIDTH-1:0]    raw_p;
        logic [APPROX_K-1:0] ab_or;
        logic                a_msb;
        logic                c0;
        logic                mode;
    } beat_t;

    beat_t            s0_d;
    beat_t            stg_d [0:L];
    beat_t            stg_q [0:L];
    logic [L:0]       vld_q;
    logic [WIDTH-1:0] lvl_g [1:L];
    logic [WIDTH-1:0] lvl_p [1:L];
    logic             stall;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Approx mode seeds g[K-1] with the AND carry and clears p[K-1], so the
    // prefix tree delivers exactly that carry into bit K and nothing from below.
    always_comb begin
        s0_d       = '0;
        s0_d.raw_p = a ^ b;
        s0_d.ab_or = a[APPROX_K-1:0] | b[APPROX_K-1:0];
        s0_d.a_msb = a[WIDTH-1];
        s0_d.mode  = mode;
        s0_d.p     = a ^ b;
        s0_d.g     = a & b;
        if (mode == MODE_EXACT) begin
            s0_d.c0   = cin;
            s0_d.g[0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
        end else begin
            s0_d.p[APPROX_K-1:0] = '0;
            s0_d.g[APPROX_K-1:0] = '0;
            s0_d.g[APPROX_K-1]   = a[APPROX_K-1] & b[APPROX_K-1];
        end
    end

    for (genvar d = 1; d <= L; d++) begin : g_level
        ksa_prefix_level #(
            .WIDTH (WIDTH),
            .SPAN  (1 << (d - 1))
        ) u_level (
            .g_in  (stg_q[d-1].g),
            .p_in  (stg_q[d-1].p),
            .g_out (lvl_g[d]),
            .p_out (lvl_p[d])
        );
    end

    always_comb begin
        stg_d[0] = s0_d;
        for (int d = 1; d <= L; d++) begin
            stg_d[d]   = stg_q[d-1];
            stg_d[d].g = lvl_g[d];
            stg_d[d].p = lvl_p[d];
        end
    end

    // After the last level G[i] is the carry out of bit i.
    always_comb begin
        carry  = {stg_q[L].g[WIDTH-2:0], stg_q[L].c0};
        sum_d  = stg_q[L].raw_p ^ carry;
        if (stg_q[L].mode == MODE_APPROX) begin
            sum_d[APPROX_K-1:0] = stg_q[L].ab_or;
        end
        cout_d = stg_q[L].g[WIDTH-1];
        ovf_d  = ~stg_q[L].raw_p[WIDTH-1] & (sum_d[WIDTH-1] ^ stg_q[L].a_msb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d <= L; d++) begin
                stg_q[d] <= '0;
            end
            vld_q     <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (!stall) begin
            for (int d = 0; d <= L; d++) begin
                stg_q[d] <= stg_d[d];
            end
            vld_q     <= {vld_q[L-1:0], in_valid};
            out_valid <= vld_q[L];
            sum       <= sum_d;
            cout      <= cout_d;
            ovf       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_ksa_pipe_adder.sv
// Self-checking bench for ksa_pipe_adder: directed vector table, stall/stream and
// reset sequences, then a long random run against an arithmetic reference model.
module tb_ksa_pipe_adder;

    localparam int W   = 16;
    localparam int K   = 4;
    localparam int LAT = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_xfer = 0;
    int last_xfer_cyc = 0;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         mode;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    res_t expq[$];

    ksa_pipe_adder #(.WIDTH(W), .APPROX_K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Reference: exact is a plain add; approx ORs the low K bits and adds the
    // upper bits with a carry of a[K-1]&b[K-1].
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic m);
        res_t         r;
        logic [W:0]   full;
        logic [W:0]   hi;
        logic [W-1:0] lo_mask;
        lo_mask = {W{1'b1}} >> (W - K);
        if (m == 1'b0) begin
            full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
            r.sum  = full[W-1:0];
            r.cout = full[W];
        end else begin
            hi     = ({1'b0, x} >> K) + ({1'b0, y} >> K) + {{W{1'b0}}, x[K-1] & y[K-1]};
            r.sum  = (hi[W-1:0] << K) | ((x | y) & lo_mask);
            r.cout = hi[W-K];
        end
        r.ovf = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: inputs and outputs are sampled at negedge, where they equal
    // what the next rising edge will see.
    initial begin
        logic hold_v;
        res_t hold_r;
        res_t e;
        hold_v = 1'b0;
        hold_r = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    chk("hold_valid", {31'b0, out_valid}, 32'd1);
                    chk("hold_data", {14'b0, sum, cout, ovf}, {14'b0, hold_r});
                end
                if (in_valid && in_ready) begin
                    expq.push_back(model(a, b, cin, mode));
                end
                if (out_valid && out_ready) begin
                    n_xfer++;
                    last_xfer_cyc = cyc;
                    checks++;
                    if (expq.size() == 0) begin
                        failures++;
                        $display("FAIL spurious_result: got sum=0x%0h with nothing outstanding", sum);
                    end else begin
                        e = expq.pop_front();
                        if ({sum, cout, ovf} !== e) begin
                            failures++;
                            $display("FAIL result: got sum=0x%0h cout=%0b ovf=%0b expected sum=0x%0h cout=%0b ovf=%0b",
                                     sum, cout, ovf, e.sum, e.cout, e.ovf);
                        end
                    end
                end
                hold_v = out_valid && !out_ready;
                hold_r = '{sum, cout, ovf};
            end
        end
    end

    task automatic run_vec(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic vc, input logic vm, input logic [W-1:0] es,
                           input logic ec, input logic eo);
        int   lat;
        logic got;
        @(posedge clk);
        #1;
        a = va; b = vb; cin = vc; mode = vm;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        while (!got && lat < 30) begin
            if (out_valid) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        chk({nm, "_latency"}, lat, LAT);
        chk({nm, "_sum"}, {16'b0, sum}, {16'b0, es});
        chk({nm, "_cout"}, {31'b0, cout}, {31'b0, ec});
        chk({nm, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
    endtask

    initial begin
        vec_t vecs[8];
        res_t r;
        logic [W-1:0] sa[8];
        logic [W-1:0] sb[8];
        logic         sc[8];
        int j;
        int first_acc;
        int n0;
        int sent;
        int guard;
        logic bad;

        vecs[0] = '{"ex_ffff_1",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{"ex_7fff_1",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{"ex_1234_cin",  16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[3] = '{"ap_000f_1",    16'h000F, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b0, 1'b0};
        vecs[4] = '{"ap_0008_8",    16'h0008, 16'h0008, 1'b0, 1'b1, 16'h0018, 1'b0, 1'b0};
        vecs[5] = '{"ex_8000_8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{"ap_fff8_8",    16'hFFF8, 16'h0008, 1'b1, 1'b1, 16'h0008, 1'b1, 1'b0};
        vecs[7] = '{"ap_7ff0_10",   16'h7FF0, 16'h0010, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        // Reset state
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_sum", {16'b0, sum}, 32'd0);
        chk("rst_cout", {31'b0, cout}, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].mode,
                    vecs[i].sum, vecs[i].cout, vecs[i].ovf);
        end
        repeat (3) @(posedge clk);

        // Stream of 8 alternating-mode beats with a 3-cycle out_ready drop
        for (int i = 0; i < 8; i++) begin
            sa[i] = W'($urandom);
            sb[i] = W'($urandom);
            sc[i] = 1'($urandom_range(0, 1));
        end
        j = 0;
        first_acc = 0;
        n0 = n_xfer;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #1;
            out_ready = !(t >= 7 && t <= 9);
            in_valid  = (j < 8);
            if (j < 8) begin
                a = sa[j]; b = sb[j]; cin = sc[j]; mode = j[0];
            end
            @(negedge clk);
            chk($sformatf("stream_in_ready_t%0d", t), {31'b0, in_ready},
                (t >= 7 && t <= 9) ? 32'd0 : 32'd1);
            if (in_valid && in_ready) begin
                if (j == 0) first_acc = cyc;
                j++;
            end
        end
        chk("stream_count", n_xfer - n0, 8);
        chk("stream_total_cycles", last_xfer_cyc - first_acc, 16);

        // Reset with three beats in flight
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'b0; mode = i[0];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("prerst_out_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        expq.delete();
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("arst_sum", {16'b0, sum}, 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) bad = 1'b1;
        end
        chk("no_out_after_rst", {31'b0, bad}, 32'd0);
        r = model(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
        run_vec("post_rst", 16'h0F0F, 16'h00F1, 1'b1, 1'b0, r.sum, r.cout, r.ovf);
        repeat (2) @(posedge clk);

        // Random traffic with random backpressure
        n0 = n_xfer;
        sent = 0;
        guard = 0;
        while (sent < 10000 && guard < 60000) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 70);
            a    = W'($urandom);
            b    = ($urandom_range(0, 3) == 0) ? ~a : W'($urandom);
            cin  = 1'($urandom_range(0, 1));
            mode = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            guard++;
        end
        chk("random_sent", sent, 10000);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (expq.size() != 0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        chk("drain_empty", expq.size(), 0);
        chk("random_count", n_xfer - n0, 10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
